program_counter_escalonador: RTL and testbench

Parametrised program counter with a built-in round-robin preemption scheduler. It holds up to NUM_PROC user-process contexts, each a saved PC, and tracks whether the OS or a user process is running. It forces entry to the OS vector on quantum expiry or process halt, and restores a process PC on dispatch. It sits at the head of the fetch path, between the next-PC mux (`pc_in`) and instruction memory, and generalises the single-context preemptive PC.

---
 rtl/program_counter_escalonador_if.sv | 45 ++++
 rtl/program_counter_escalonador.sv | 143 ++++++++++++++
 tb/tb_program_counter_escalonador.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_counter_escalonador_if.sv
// Fetch-side bundle of the preemptive PC: datapath/OS controls in (master drives),
// PC, slice and scheduler status out (slave drives).
interface program_counter_escalonador_if #(
  parameter int PC_WIDTH      = 32,
  parameter int NUM_PROC      = 4,
  parameter int QUANTUM_WIDTH = 5
);
  localparam int ID_W = ($clog2(NUM_PROC) > 1) ? $clog2(NUM_PROC) : 1;

  logic [PC_WIDTH-1:0]      pc_in;
  logic                     stall;
  logic                     modo_preemptivo;
  logic [QUANTUM_WIDTH-1:0] quantum;
  logic                     halt;
  logic                     despacha;
  logic [ID_W-1:0]          proc_sel;
  logic                     ctx_we;
  logic [ID_W-1:0]          ctx_id;
  logic [PC_WIDTH-1:0]      ctx_pc;

  logic [PC_WIDTH-1:0]      pc;
  logic [PC_WIDTH-1:0]      pc_mais_1;
  logic [QUANTUM_WIDTH-1:0] cont_preempcao;
  logic                     flag_faz_preempcao;
  logic                     motivo_halt;
  logic                     em_usuario;
  logic [ID_W-1:0]          proc_ativo;
  logic [NUM_PROC-1:0]      proc_vivo;
  logic [ID_W-1:0]          proximo_proc;
  logic                     nenhum_vivo;

  modport master (
    output pc_in, stall, modo_preemptivo, quantum, halt, despacha, proc_sel,
           ctx_we, ctx_id, ctx_pc,
    input  pc, pc_mais_1, cont_preempcao, flag_faz_preempcao, motivo_halt,
           em_usuario, proc_ativo, proc_vivo, proximo_proc, nenhum_vivo
  );

  modport slave (
    input  pc_in, stall, modo_preemptivo, quantum, halt, despacha, proc_sel,
           ctx_we, ctx_id, ctx_pc,
    output pc, pc_mais_1, cont_preempcao, flag_faz_preempcao, motivo_halt,
           em_usuario, proc_ativo, proc_vivo, proximo_proc, nenhum_vivo
  );
endinterface

// File: rtl/program_counter_escalonador.sv
// Program counter with a round-robin preemption scheduler: keeps NUM_PROC saved user
// PCs and forces entry to the OS vector on quantum expiry or process halt.
module program_counter_escalonador #(
  parameter int                  PC_WIDTH      = 32,
  parameter int                  NUM_PROC      = 4,
  parameter int                  QUANTUM_WIDTH = 5,
  parameter logic [PC_WIDTH-1:0] SO_VECTOR     = PC_WIDTH'(3),
  parameter logic [PC_WIDTH-1:0] RESET_PC      = '0
) (
  input logic                          clock,
  input logic                          reset_geral,
  program_counter_escalonador_if.slave bus
);
  localparam int ID_W = ($clog2(NUM_PROC) > 1) ? $clog2(NUM_PROC) : 1;

  typedef enum logic {SO, USUARIO} state_t;

  state_t                   state_q, state_d;
  logic [PC_WIDTH-1:0]      pc_q, pc_d;
  logic [PC_WIDTH-1:0]      ctx_q [NUM_PROC];
  logic [PC_WIDTH-1:0]      ctx_d [NUM_PROC];
  logic [QUANTUM_WIDTH-1:0] cont_q, cont_d;
  logic                     flag_q, flag_d;
  logic                     motivo_q, motivo_d;
  logic [ID_W-1:0]          ativo_q, ativo_d;
  logic [NUM_PROC-1:0]      vivo_q, vivo_d;
  logic [QUANTUM_WIDTH:0]   cont_inc;
  logic                     quantum_expirou;
  logic                     sel_valido;
  logic                     id_valido;
  logic [ID_W-1:0]          proximo;
  logic [ID_W-1:0]          cand;
  logic                     achou;

  // One extra bit so cont+1 never wraps before being compared with quantum.
  assign cont_inc        = {1'b0, cont_q} + (QUANTUM_WIDTH+1)'(1);
  assign quantum_expirou = bus.modo_preemptivo && (bus.quantum != '0) &&
                           (cont_inc >= {1'b0, bus.quantum});
  assign sel_valido      = int'(bus.proc_sel) < NUM_PROC;
  assign id_valido       = int'(bus.ctx_id) < NUM_PROC;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cont_d   = cont_q;
    flag_d   = 1'b0;
    motivo_d = 1'b0;
    ativo_d  = ativo_q;
    vivo_d   = vivo_q;
    ctx_d    = ctx_q;
    if (bus.ctx_we && id_valido) begin
      ctx_d[bus.ctx_id] = bus.ctx_pc;
    end
    if (!bus.stall) begin
      unique case (state_q)
        SO: begin
          if (bus.despacha && sel_valido && vivo_q[bus.proc_sel]) begin
            pc_d    = ctx_q[bus.proc_sel];
            ativo_d = bus.proc_sel;
            cont_d  = '0;
            state_d = USUARIO;
          end else begin
            pc_d = bus.pc_in;
          end
        end
        USUARIO: begin
          if (bus.halt) begin
            vivo_d[ativo_q] = 1'b0;
            pc_d     = SO_VECTOR;
            flag_d   = 1'b1;
            motivo_d = 1'b1;
            cont_d   = '0;
            state_d  = SO;
          end else if (quantum_expirou) begin
            // Placed after the ctx_we write so the preemption save wins a collision.
            ctx_d[ativo_q] = bus.pc_in;
            pc_d     = SO_VECTOR;
            flag_d   = 1'b1;
            cont_d   = '0;
            state_d  = SO;
          end else begin
            pc_d   = bus.pc_in;
            cont_d = bus.modo_preemptivo ? cont_inc[QUANTUM_WIDTH-1:0] : '0;
          end
        end
        default: ;
      endcase
    end
    // Applied last so a context write revives a process halting in the same cycle.
    if (bus.ctx_we && id_valido) begin
      vivo_d[bus.ctx_id] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset_geral) begin
    if (reset_geral) begin
      state_q  <= SO;
      pc_q     <= RESET_PC;
      cont_q   <= '0;
      flag_q   <= 1'b0;
      motivo_q <= 1'b0;
      ativo_q  <= '0;
      vivo_q   <= '0;
      for (int i = 0; i < NUM_PROC; i++) begin
        ctx_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cont_q   <= cont_d;
      flag_q   <= flag_d;
      motivo_q <= motivo_d;
      ativo_q  <= ativo_d;
      vivo_q   <= vivo_d;
      ctx_q    <= ctx_d;
    end
  end

  // Round-robin search starting just after the active process, ending on it.
  always_comb begin
    proximo = ativo_q;
    achou   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NUM_PROC; i++) begin
      cand = ID_W'((int'(ativo_q) + i) % NUM_PROC);
      if (!achou && vivo_q[cand]) begin
        proximo = cand;
        achou   = 1'b1;
      end
    end
  end

  assign bus.pc                 = pc_q;
  assign bus.pc_mais_1          = pc_q + PC_WIDTH'(1);
  assign bus.cont_preempcao     = cont_q;
  assign bus.flag_faz_preempcao = flag_q;
  assign bus.motivo_halt        = motivo_q;
  assign bus.em_usuario         = (state_q == USUARIO);
  assign bus.proc_ativo         = ativo_q;
  assign bus.proc_vivo          = vivo_q;
  assign bus.proximo_proc       = proximo;
  assign bus.nenhum_vivo        = (vivo_q == '0);
endmodule

// File: tb/tb_program_counter_escalonador.sv
// Directed scenarios plus random traffic for program_counter_escalonador, checked
// against a cycle-level reference model of the scheduling rules.
module tb_program_counter_escalonador;
  localparam int          PW  = 32;
  localparam int          NP  = 4;
  localparam int          QW  = 5;
  localparam logic [31:0] SOV = 32'd3;

  logic clock = 1'b0;
  logic reset_geral = 1'b1;

  program_counter_escalonador_if #(.PC_WIDTH(PW), .NUM_PROC(NP), .QUANTUM_WIDTH(QW)) bus ();

  program_counter_escalonador #(
    .PC_WIDTH(PW), .NUM_PROC(NP), .QUANTUM_WIDTH(QW), .SO_VECTOR(SOV), .RESET_PC(32'd0)
  ) dut (
    .clock(clock),
    .reset_geral(reset_geral),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int          nChecks = 0;
  int          nErrors = 0;
  logic [31:0] mPc;
  int          mCont;
  bit          mUser;
  int          mActive;
  logic [31:0] mCtx [NP];
  bit          mAlive [NP];
  bit          mFlag;
  bit          mMotivo;

  function automatic logic [31:0] aliveMask();
    logic [31:0] m = '0;
    for (int i = 0; i < NP; i++) m[i] = mAlive[i];
    return m;
  endfunction

  function automatic int nextCandidate();
    for (int k = 1; k <= NP; k++) begin
      if (mAlive[(mActive + k) % NP]) return (mActive + k) % NP;
    end
    return mActive;
  endfunction

  task automatic modelReset();
    mPc = 0; mCont = 0; mUser = 0; mActive = 0; mFlag = 0; mMotivo = 0;
    for (int i = 0; i < NP; i++) begin
      mCtx[i] = 0;
      mAlive[i] = 0;
    end
  endtask

  // Reference view: the scheduler's next state from the inputs presented before an edge.
  task automatic modelEdge();
    bit          doSave = 0;
    bit          doKill = 0;
    int          sel = int'(bus.proc_sel);
    int          wid = int'(bus.ctx_id);
    logic [31:0] pcIn = bus.pc_in;
    logic [31:0] oldCtx [NP];
    for (int i = 0; i < NP; i++) oldCtx[i] = mCtx[i];
    mFlag = 0;
    mMotivo = 0;
    if (!bus.stall) begin
      if (!mUser) begin
        if (bus.despacha && mAlive[sel]) begin
          mPc = oldCtx[sel]; mActive = sel; mCont = 0; mUser = 1;
        end else begin
          mPc = pcIn;
        end
      end else if (bus.halt) begin
        doKill = 1; mPc = SOV; mFlag = 1; mMotivo = 1; mCont = 0; mUser = 0;
      end else if (bus.modo_preemptivo && bus.quantum != 0 && mCont + 1 >= int'(bus.quantum)) begin
        doSave = 1; mPc = SOV; mFlag = 1; mCont = 0; mUser = 0;
      end else begin
        mPc = pcIn;
        mCont = bus.modo_preemptivo ? (mCont + 1) % 32 : 0;
      end
    end
    if (doKill) mAlive[mActive] = 0;
    if (bus.ctx_we) begin
      mCtx[wid] = bus.ctx_pc;
      mAlive[wid] = 1;
    end
    if (doSave) mCtx[mActive] = pcIn;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    assert (got === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".pc"}, bus.pc, mPc);
    checkVal({tag, ".pc_mais_1"}, bus.pc_mais_1, mPc + 32'd1);
    checkVal({tag, ".cont"}, 32'(bus.cont_preempcao), 32'(mCont));
    checkVal({tag, ".flag"}, 32'(bus.flag_faz_preempcao), 32'(mFlag));
    checkVal({tag, ".motivo"}, 32'(bus.motivo_halt), 32'(mMotivo));
    checkVal({tag, ".em_usuario"}, 32'(bus.em_usuario), 32'(mUser));
    checkVal({tag, ".proc_ativo"}, 32'(bus.proc_ativo), 32'(mActive));
    checkVal({tag, ".proc_vivo"}, 32'(bus.proc_vivo), aliveMask());
    checkVal({tag, ".proximo"}, 32'(bus.proximo_proc), 32'(nextCandidate()));
    checkVal({tag, ".nenhum_vivo"}, 32'(bus.nenhum_vivo), 32'(aliveMask() == 0));
  endtask

  task automatic applyStimulus();
    modelEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic setIdle();
    bus.stall = 0; bus.halt = 0; bus.despacha = 0; bus.ctx_we = 0;
  endtask

  initial begin
    int flagAt;
    int flagCount;
    setIdle();
    bus.pc_in = 0; bus.modo_preemptivo = 0; bus.quantum = 0;
    bus.proc_sel = 0; bus.ctx_id = 0; bus.ctx_pc = 0;
    modelReset();
    #2;
    checkOutput("reset");
    checkVal("reset.pc_mais_1_const", bus.pc_mais_1, 32'd1);
    @(negedge clock);
    reset_geral = 0;

    // Quantum preemption of process 1 after exactly four instructions.
    bus.ctx_we = 1; bus.ctx_id = 1; bus.ctx_pc = 40; bus.pc_in = 7;
    applyStimulus(); checkOutput("ctxwr");
    checkVal("ctxwr.pc_follows", bus.pc, 32'd7);
    setIdle();
    bus.modo_preemptivo = 1; bus.quantum = 4; bus.despacha = 1; bus.proc_sel = 1; bus.pc_in = 99;
    applyStimulus(); checkOutput("disp1");
    checkVal("disp1.pc", bus.pc, 32'd40);
    bus.despacha = 0;
    for (int i = 0; i < 4; i++) begin
      bus.pc_in = mPc + 1;
      applyStimulus(); checkOutput("slice");
    end
    checkVal("quantum.pc", bus.pc, 32'd3);
    checkVal("quantum.flag", 32'(bus.flag_faz_preempcao), 32'd1);
    checkVal("quantum.motivo", 32'(bus.motivo_halt), 32'd0);
    bus.despacha = 1; bus.proc_sel = 1; bus.pc_in = 5;
    applyStimulus(); checkOutput("redisp");
    checkVal("redisp.pc", bus.pc, 32'd44);

    // Asynchronous reset in the middle of a slice.
    bus.despacha = 0; bus.pc_in = mPc + 1;
    applyStimulus(); checkOutput("pre_reset");
    #2 reset_geral = 1;
    modelReset();
    #1;
    checkOutput("midreset");
    checkVal("midreset.pc", bus.pc, 32'd0);
    checkVal("midreset.em_usuario", 32'(bus.em_usuario), 32'd0);
    checkVal("midreset.vivo", 32'(bus.proc_vivo), 32'd0);
    @(negedge clock);
    reset_geral = 0;

    // Halt on the second user cycle of process 0.
    bus.modo_preemptivo = 0;
    bus.ctx_we = 1; bus.ctx_id = 0; bus.ctx_pc = 10; bus.pc_in = 0;
    applyStimulus(); checkOutput("ctx0");
    bus.ctx_id = 2; bus.ctx_pc = 20;
    applyStimulus(); checkOutput("ctx2");
    setIdle();
    bus.despacha = 1; bus.proc_sel = 0;
    applyStimulus(); checkOutput("disp0");
    checkVal("disp0.pc", bus.pc, 32'd10);
    bus.despacha = 0; bus.pc_in = mPc + 1;
    applyStimulus(); checkOutput("user2");
    bus.halt = 1; bus.pc_in = mPc + 1;
    applyStimulus(); checkOutput("halt");
    checkVal("halt.pc", bus.pc, 32'd3);
    checkVal("halt.flag", 32'(bus.flag_faz_preempcao), 32'd1);
    checkVal("halt.motivo", 32'(bus.motivo_halt), 32'd1);
    checkVal("halt.vivo", 32'(bus.proc_vivo), 32'b0100);
    checkVal("halt.proximo", 32'(bus.proximo_proc), 32'd2);

    // Stall for three cycles inside a six-instruction slice.
    setIdle();
    bus.modo_preemptivo = 1; bus.quantum = 6; bus.despacha = 1; bus.proc_sel = 2;
    applyStimulus(); checkOutput("disp2");
    bus.despacha = 0;
    flagAt = -1;
    for (int e = 1; e <= 30 && flagAt < 0; e++) begin
      bus.stall = (e >= 3 && e <= 5);
      bus.pc_in = mPc + 1;
      applyStimulus(); checkOutput("stall");
      if (bus.flag_faz_preempcao) flagAt = e;
    end
    bus.stall = 0;
    checkVal("stall.slice_edges", 32'(flagAt), 32'd9);

    // Non-preemptive mode: forty cycles with no forced entry.
    bus.modo_preemptivo = 0; bus.despacha = 1; bus.proc_sel = 2;
    applyStimulus(); checkOutput("disp2b");
    checkVal("disp2b.pc_saved", bus.pc, 32'd26);
    bus.despacha = 0;
    flagCount = 0;
    for (int i = 0; i < 40; i++) begin
      bus.pc_in = mPc + 1;
      applyStimulus(); checkOutput("modo0");
      flagCount += int'(bus.flag_faz_preempcao);
    end
    checkVal("modo0.flags", 32'(flagCount), 32'd0);
    checkVal("modo0.cont", 32'(bus.cont_preempcao), 32'd0);

    // Dead dispatch, zero quantum, lowered quantum, save/write collision.
    bus.halt = 1;
    applyStimulus(); checkOutput("halt2");
    checkVal("halt2.nenhum_vivo", 32'(bus.nenhum_vivo), 32'd1);
    setIdle();
    bus.despacha = 1; bus.proc_sel = 3; bus.pc_in = 77;
    applyStimulus(); checkOutput("deaddisp");
    checkVal("deaddisp.pc", bus.pc, 32'd77);
    setIdle();
    bus.ctx_we = 1; bus.ctx_id = 0; bus.ctx_pc = 100;
    applyStimulus(); checkOutput("ctx0b");
    setIdle();
    bus.modo_preemptivo = 1; bus.quantum = 0; bus.despacha = 1; bus.proc_sel = 0;
    applyStimulus(); checkOutput("disp0b");
    bus.despacha = 0;
    flagCount = 0;
    for (int i = 0; i < 40; i++) begin
      bus.pc_in = mPc + 1;
      applyStimulus(); checkOutput("q0");
      flagCount += int'(bus.flag_faz_preempcao);
    end
    checkVal("q0.flags", 32'(flagCount), 32'd0);
    checkVal("q0.em_usuario", 32'(bus.em_usuario), 32'd1);
    bus.halt = 1;
    applyStimulus(); checkOutput("halt3");
    setIdle();
    bus.ctx_we = 1; bus.ctx_id = 0; bus.ctx_pc = 200;
    applyStimulus(); checkOutput("ctx0c");
    setIdle();
    bus.quantum = 8; bus.despacha = 1; bus.proc_sel = 0;
    applyStimulus(); checkOutput("disp0c");
    bus.despacha = 0;
    for (int i = 0; i < 5; i++) begin
      bus.pc_in = mPc + 1;
      applyStimulus(); checkOutput("q8");
    end
    checkVal("q8.cont", 32'(bus.cont_preempcao), 32'd5);
    bus.quantum = 2; bus.pc_in = mPc + 1;
    bus.ctx_we = 1; bus.ctx_id = 0; bus.ctx_pc = 999;
    applyStimulus(); checkOutput("lowerq");
    checkVal("lowerq.flag", 32'(bus.flag_faz_preempcao), 32'd1);
    checkVal("lowerq.pc", bus.pc, 32'd3);
    setIdle();
    bus.quantum = 0; bus.despacha = 1; bus.proc_sel = 0;
    applyStimulus(); checkOutput("collide");
    checkVal("collide.pc_saved", bus.pc, 32'd206);

    // PC wrap-around.
    setIdle();
    bus.halt = 1;
    applyStimulus(); checkOutput("halt4");
    setIdle();
    bus.ctx_we = 1; bus.ctx_id = 1; bus.ctx_pc = 32'hFFFF_FFFF;
    applyStimulus(); checkOutput("ctxwrap");
    setIdle();
    bus.despacha = 1; bus.proc_sel = 1;
    applyStimulus(); checkOutput("wrap");
    checkVal("wrap.pc_mais_1", bus.pc_mais_1, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.stall = ($urandom_range(0, 7) == 0);
      bus.halt = ($urandom_range(0, 9) == 0);
      bus.despacha = ($urandom_range(0, 2) == 0);
      bus.proc_sel = 2'($urandom_range(0, 3));
      bus.ctx_we = ($urandom_range(0, 5) == 0);
      bus.ctx_id = 2'($urandom_range(0, 3));
      bus.ctx_pc = $urandom;
      bus.quantum = 5'($urandom_range(0, 7));
      bus.modo_preemptivo = ($urandom_range(0, 3) != 0);
      bus.pc_in = $urandom;
      applyStimulus(); checkOutput("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
